// File: rtl/duck_pkg.sv
// ---------------------------------------------------------------------------
// duck_pkg
// Shared constants and types for the duck sprite address generator.
//   - Default sprite geometry (frame size and sprite-sheet row pitch).
//   - Sprite-sheet frame indices: two wing-flap poses and the shot pose.
//   - The animation state enum (FLY=0, HIT=1, FALL=2).
//   - frameFor(): maps an animation state and flap phase to a sheet frame.
// ---------------------------------------------------------------------------
package duck_pkg;

    localparam int DEF_SPRITE_W = 50;
    localparam int DEF_SPRITE_H = 50;
    localparam int DEF_SHEET_W  = 150;

    localparam logic [1:0] FRAME_WING_UP   = 2'd0;
    localparam logic [1:0] FRAME_WING_DOWN = 2'd1;
    localparam logic [1:0] FRAME_SHOT      = 2'd2;

    typedef enum logic [1:0] {
        ST_FLY  = 2'd0,
        ST_HIT  = 2'd1,
        ST_FALL = 2'd2
    } anim_state_t;

    // While flying, the flap phase picks between the two wing poses; every
    // other state shows the shot pose (FALL adds a vertical flip elsewhere).
    function automatic logic [1:0] frameFor(input anim_state_t state, input logic flapPhase);
        if (state == ST_FLY) begin
            return flapPhase ? FRAME_WING_DOWN : FRAME_WING_UP;
        end
        return FRAME_SHOT;
    endfunction

endpackage

// File: rtl/duck_anim_fsm.sv
// ---------------------------------------------------------------------------
// duck_anim_fsm
// Animation state machine for the duck sprite plus its frame_tick counter.
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-low reset
//   frame_tick_i   one-cycle pulse per video frame
//   shot_i         duck-hit pulse (acted on only in FLY)
//   revive_i       respawn pulse (acted on only in FALL)
//   state_o        current animation state, changes on the same edge as the event
//   frame_sel_o    sprite-sheet frame for the address path, changes only on frame_tick
//   flip_o         vertical flip for the address path, changes only on frame_tick
// ---------------------------------------------------------------------------
module duck_anim_fsm
    import duck_pkg::*;
#(
    parameter int FLAP_TICKS = 8,
    parameter int HIT_TICKS  = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_tick_i,
    input  logic        shot_i,
    input  logic        revive_i,
    output anim_state_t state_o,
    output logic [1:0]  frame_sel_o,
    output logic        flip_o
);

    localparam logic [4:0] FLAP_LAST = 5'(FLAP_TICKS - 1);
    localparam logic [4:0] HIT_LAST  = 5'(HIT_TICKS - 1);

    anim_state_t state_q, state_d;
    logic [4:0]  tickCnt_q, tickCnt_d;
    logic        flapPhase_q, flapPhase_d;
    logic [1:0]  frameSel_q, frameSel_d;
    logic        flip_q, flip_d;

    // State, tick counter, flap phase and the address-path flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_FLY;
            tickCnt_q   <= '0;
            flapPhase_q <= 1'b0;
            frameSel_q  <= FRAME_WING_UP;
            flip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            flapPhase_q <= flapPhase_d;
            frameSel_q  <= frameSel_d;
            flip_q      <= flip_d;
        end
    end

    // Next-state logic. shot is checked before frame_tick in FLY so a shot
    // landing on a tick clears the counter instead of advancing the flap.
    // The frame and flip flags are latched from the *next* state on a tick,
    // so a transition coinciding with a tick shows the new pose right away.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        flapPhase_d = flapPhase_q;
        frameSel_d  = frameSel_q;
        flip_d      = flip_q;

        case (state_q)
            ST_FLY: begin
                if (shot_i) begin
                    state_d   = ST_HIT;
                    tickCnt_d = '0;
                end else if (frame_tick_i) begin
                    if (tickCnt_q == FLAP_LAST) begin
                        tickCnt_d   = '0;
                        flapPhase_d = ~flapPhase_q;
                    end else begin
                        tickCnt_d = tickCnt_q + 5'd1;
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick_i) begin
                    if (tickCnt_q == HIT_LAST) begin
                        state_d   = ST_FALL;
                        tickCnt_d = '0;
                    end else begin
                        tickCnt_d = tickCnt_q + 5'd1;
                    end
                end
            end
            ST_FALL: begin
                if (revive_i) begin
                    state_d     = ST_FLY;
                    tickCnt_d   = '0;
                    flapPhase_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_FLY;
                tickCnt_d   = '0;
                flapPhase_d = 1'b0;
            end
        endcase

        if (frame_tick_i) begin
            frameSel_d = frameFor(state_d, flapPhase_d);
            flip_d     = (state_d == ST_FALL);
        end
    end

    assign state_o     = state_q;
    assign frame_sel_o = frameSel_q;
    assign flip_o      = flip_q;

endmodule

// File: rtl/duck_sprite_addr_gen.sv
// ---------------------------------------------------------------------------
// duck_sprite_addr_gen
// Turns the current raster position into a sprite-sheet ROM address for the
// duck and tracks the duck's animation.
// Optional feature: define DUCK_MIRROR_EN to mirror the sprite horizontally
// while dir_left (latched on frame_tick) is high; without it dir_left is ignored.
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   hcount      current pixel column
//   vcount      current pixel row
//   duck_x      sprite left edge
//   duck_y      sprite top edge
//   frame_tick  one-cycle pulse per video frame
//   shot        duck-hit pulse
//   revive      respawn pulse
//   dir_left    duck flying left
//   addr        sprite ROM address, one cycle after hcount/vcount (0 outside the box)
//   sprite_hit  pixel inside the sprite box, two cycles after hcount/vcount
//   anim_state  current animation state (FLY=0, HIT=1, FALL=2)
// ---------------------------------------------------------------------------
module duck_sprite_addr_gen
    import duck_pkg::*;
#(
    parameter int SPRITE_W   = DEF_SPRITE_W,
    parameter int SPRITE_H   = DEF_SPRITE_H,
    parameter int SHEET_W    = DEF_SHEET_W,
    parameter int FLAP_TICKS = 8,
    parameter int HIT_TICKS  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  duck_x,
    input  logic [9:0]  duck_y,
    input  logic        frame_tick,
    input  logic        shot,
    input  logic        revive,
    input  logic        dir_left,
    output logic [12:0] addr,
    output logic        sprite_hit,
    output logic [1:0]  anim_state
);

    anim_state_t animState;
    logic [1:0]  frameSel;
    logic        flip;

    duck_anim_fsm #(
        .FLAP_TICKS (FLAP_TICKS),
        .HIT_TICKS  (HIT_TICKS)
    ) u_anim (
        .clk_i        (clk),
        .rst_i        (rst),
        .frame_tick_i (frame_tick),
        .shot_i       (shot),
        .revive_i     (revive),
        .state_o      (animState),
        .frame_sel_o  (frameSel),
        .flip_o       (flip)
    );

    // Box bounds are compared in 11 bits so a sprite near the right/bottom
    // edge does not wrap its far edge back past 1023.
    logic [10:0] hExt, vExt, xExt, yExt;
    logic        inBox;

    assign hExt  = {1'b0, hcount};
    assign vExt  = {1'b0, vcount};
    assign xExt  = {1'b0, duck_x};
    assign yExt  = {1'b0, duck_y};
    assign inBox = (hExt >= xExt) && (hExt < xExt + 11'(SPRITE_W)) &&
                   (vExt >= yExt) && (vExt < yExt + 11'(SPRITE_H));

    // Offsets inside the box; only meaningful when inBox is set.
    logic [9:0] col, row, colEff, rowEff;

    assign col    = hcount - duck_x;
    assign row    = vcount - duck_y;
    assign rowEff = flip ? (10'(SPRITE_H - 1) - row) : row;

`ifdef DUCK_MIRROR_EN
    logic mirror_q;

    // Facing direction is sampled only on frame_tick, like the other
    // address-path flags, so a frame is never drawn half mirrored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mirror_q <= 1'b0;
        end else if (frame_tick) begin
            mirror_q <= dir_left;
        end
    end

    assign colEff = mirror_q ? (10'(SPRITE_W - 1) - col) : col;
`else
    logic unusedDirLeft;

    assign unusedDirLeft = dir_left;
    assign colEff        = col;
`endif

    logic [12:0] pixelAddr, addr_d;

    assign pixelAddr = 13'(rowEff) * 13'(SHEET_W) +
                       13'(frameSel) * 13'(SPRITE_W) +
                       13'(colEff);
    assign addr_d    = inBox ? pixelAddr : 13'd0;

    logic [12:0] addr_q;
    logic        inBox_q, hit_q;

    // Address register plus a two-deep in-box pipeline; the second stage
    // lines sprite_hit up with the data coming back from the ROM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            inBox_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            inBox_q <= inBox;
            hit_q   <= inBox_q;
        end
    end

    assign addr       = addr_q;
    assign sprite_hit = hit_q;
    assign anim_state = animState;

endmodule
